// File: rtl/des_wb_master.sv
// des_wb_master
// Wishbone initiator that takes one DES job (key, 64-bit text, direction)
// from a valid/ready request port. It walks the DES peripheral's register map
// with single transactions: load the key and input, start, poll status, read
// the result, clear control. It then returns {out_hi, out_lo} and an error
// flag on a valid/ready response port.
//
// Ports
//   clk, reset                      clock, synchronous active-high reset
//   i_req_valid / o_req_ready       job handshake (ready only while idle)
//   i_req_key, i_req_text           64-bit key and text block
//   i_req_encrypt                   1 = encrypt, 0 = decrypt
//   o_rsp_valid / i_rsp_ready       result handshake
//   o_rsp_text, o_rsp_err           result block, abort flag (poll/ack timeout)
//   o_wb_cyc/stb/we/addr/data       Wishbone master outputs
//   i_wb_ack/stall/data             Wishbone slave responses
module des_wb_master #(
    parameter logic [31:0] BASE_ADDRESS = 32'h3000_0000,
    parameter int          POLL_LIMIT   = 64,
    parameter int          ACK_TIMEOUT  = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic [63:0] i_req_key,
    input  logic [63:0] i_req_text,
    input  logic        i_req_encrypt,
    output logic        o_rsp_valid,
    input  logic        i_rsp_ready,
    output logic [63:0] o_rsp_text,
    output logic        o_rsp_err,
    output logic        o_wb_cyc,
    output logic        o_wb_stb,
    output logic        o_wb_we,
    output logic [31:0] o_wb_addr,
    output logic [31:0] o_wb_data,
    input  logic        i_wb_ack,
    input  logic        i_wb_stall,
    input  logic [31:0] i_wb_data
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_XFER = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam logic [3:0] OP_KEY_LO = 4'd0;
    localparam logic [3:0] OP_KEY_HI = 4'd1;
    localparam logic [3:0] OP_IN_LO  = 4'd2;
    localparam logic [3:0] OP_IN_HI  = 4'd3;
    localparam logic [3:0] OP_GO     = 4'd4;
    localparam logic [3:0] OP_STS    = 4'd5;
    localparam logic [3:0] OP_OUT_LO = 4'd6;
    localparam logic [3:0] OP_OUT_HI = 4'd7;
    localparam logic [3:0] OP_CLR    = 4'd8;

    localparam int PW = $clog2(POLL_LIMIT + 1);
    localparam int AW = $clog2(ACK_TIMEOUT + 1);
    localparam logic [PW-1:0] POLL_LAST = PW'(POLL_LIMIT - 1);
    localparam logic [AW-1:0] ACK_LAST  = AW'(ACK_TIMEOUT - 1);

    logic [1:0]    state_reg;
    logic [3:0]    op_reg;
    logic          stb_reg;
    logic [PW-1:0] poll_cnt_reg;
    logic [AW-1:0] ack_cnt_reg;
    logic [63:0]   key_reg;
    logic [63:0]   text_reg;
    logic          encrypt_reg;
    logic [31:0]   out_lo_reg;
    logic [31:0]   out_hi_reg;
    logic          err_reg;

    // Address offset, direction and write data of the current operation.
    logic [7:0]  op_offset;
    logic        op_we;
    logic [31:0] op_data;

    always_comb begin
        op_offset = 8'h00;
        op_we     = 1'b0;
        op_data   = 32'h0;
        case (op_reg)
            OP_KEY_LO: begin op_offset = 8'h10; op_we = 1'b1; op_data = key_reg[31:0];  end
            OP_KEY_HI: begin op_offset = 8'h14; op_we = 1'b1; op_data = key_reg[63:32]; end
            OP_IN_LO:  begin op_offset = 8'h00; op_we = 1'b1; op_data = text_reg[31:0]; end
            OP_IN_HI:  begin op_offset = 8'h04; op_we = 1'b1; op_data = text_reg[63:32]; end
            OP_GO:     begin op_offset = 8'h18; op_we = 1'b1; op_data = {30'b0, encrypt_reg, 1'b1}; end
            OP_STS:    begin op_offset = 8'h1C; end
            OP_OUT_LO: begin op_offset = 8'h08; end
            OP_OUT_HI: begin op_offset = 8'h0C; end
            OP_CLR:    begin op_offset = 8'h18; op_we = 1'b1; op_data = 32'h0; end
            default:   begin op_offset = 8'h00; end
        endcase
    end

    // cyc covers the whole transaction; the other bus outputs are forced to
    // zero outside it so the bus is quiet while idle or responding.
    assign o_wb_cyc  = (state_reg == ST_XFER);
    assign o_wb_stb  = stb_reg;
    assign o_wb_we   = o_wb_cyc & op_we;
    assign o_wb_addr = o_wb_cyc ? (BASE_ADDRESS + {24'd0, op_offset}) : 32'h0;
    assign o_wb_data = (o_wb_cyc & op_we) ? op_data : 32'h0;

    // Ready is masked by reset so every output reads 0 while reset is held.
    assign o_req_ready = (state_reg == ST_IDLE) & ~reset;
    assign o_rsp_valid = (state_reg == ST_RESP);
    assign o_rsp_text  = o_rsp_valid ? {out_hi_reg, out_lo_reg} : 64'h0;
    assign o_rsp_err   = o_rsp_valid & err_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= ST_IDLE;
            op_reg       <= OP_KEY_LO;
            stb_reg      <= 1'b0;
            poll_cnt_reg <= '0;
            ack_cnt_reg  <= '0;
            key_reg      <= 64'h0;
            text_reg     <= 64'h0;
            encrypt_reg  <= 1'b0;
            out_lo_reg   <= 32'h0;
            out_hi_reg   <= 32'h0;
            err_reg      <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (i_req_valid) begin
                        key_reg      <= i_req_key;
                        text_reg     <= i_req_text;
                        encrypt_reg  <= i_req_encrypt;
                        op_reg       <= OP_KEY_LO;
                        stb_reg      <= 1'b1;
                        poll_cnt_reg <= '0;
                        ack_cnt_reg  <= '0;
                        out_lo_reg   <= 32'h0;
                        out_hi_reg   <= 32'h0;
                        err_reg      <= 1'b0;
                        state_reg    <= ST_XFER;
                    end
                end
                ST_XFER: begin
                    if (stb_reg && !i_wb_stall) begin
                        stb_reg <= 1'b0;
                    end
                    if (i_wb_ack) begin
                        // Next transaction strobes in the cycle right after the ack.
                        ack_cnt_reg <= '0;
                        stb_reg     <= 1'b1;
                        op_reg      <= op_reg + 4'd1;
                        case (op_reg)
                            OP_STS: begin
                                if (i_wb_data[0]) begin
                                    op_reg <= OP_OUT_LO;
                                end else if (poll_cnt_reg == POLL_LAST) begin
                                    // Give up polling but still release ctrl.
                                    op_reg  <= OP_CLR;
                                    err_reg <= 1'b1;
                                end else begin
                                    op_reg       <= OP_STS;
                                    poll_cnt_reg <= poll_cnt_reg + PW'(1);
                                end
                            end
                            OP_OUT_LO: out_lo_reg <= i_wb_data;
                            OP_OUT_HI: out_hi_reg <= i_wb_data;
                            OP_CLR: begin
                                stb_reg   <= 1'b0;
                                state_reg <= ST_RESP;
                            end
                            default: ;
                        endcase
                    end else if (ack_cnt_reg == ACK_LAST) begin
                        // Slave is unresponsive: abandon the bus, no ctrl clear.
                        stb_reg    <= 1'b0;
                        err_reg    <= 1'b1;
                        out_lo_reg <= 32'h0;
                        out_hi_reg <= 32'h0;
                        state_reg  <= ST_RESP;
                    end else begin
                        ack_cnt_reg <= ack_cnt_reg + AW'(1);
                    end
                end
                ST_RESP: begin
                    if (i_rsp_ready) begin
                        state_reg <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_des_wb_master.sv
// tb_des_wb_master
// Directed bench for des_wb_master: a register-level model of the DES
// peripheral (known-answer DES vectors, simple XOR stand-in for other data)
// answers on the bus, a table of jobs is run through the master, and a few
// hand-written sequences cover ack timeout and reset mid-transaction.
module tb_des_wb_master;
    localparam logic [31:0] BASE = 32'h3000_0000;
    localparam logic [63:0] K = 64'h1334_5779_9BBC_DFF1;
    localparam logic [63:0] P = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] C = 64'h85E8_1354_0F0A_B405;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [63:0] req_key = 64'h0;
    logic [63:0] req_text = 64'h0;
    logic        req_encrypt = 1'b0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [63:0] rsp_text;
    logic        rsp_err;
    logic        wb_cyc, wb_stb, wb_we;
    logic [31:0] wb_addr, wb_data;
    logic        wb_ack = 1'b0;
    logic        wb_stall = 1'b0;
    logic [31:0] wb_rdata = 32'h0;

    int total = 0;
    int bad = 0;

    des_wb_master #(.BASE_ADDRESS(BASE), .POLL_LIMIT(64), .ACK_TIMEOUT(16)) dut (
        .clk(clk), .reset(reset),
        .i_req_valid(req_valid), .o_req_ready(req_ready),
        .i_req_key(req_key), .i_req_text(req_text), .i_req_encrypt(req_encrypt),
        .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready),
        .o_rsp_text(rsp_text), .o_rsp_err(rsp_err),
        .o_wb_cyc(wb_cyc), .o_wb_stb(wb_stb), .o_wb_we(wb_we),
        .o_wb_addr(wb_addr), .o_wb_data(wb_data),
        .i_wb_ack(wb_ack), .i_wb_stall(wb_stall), .i_wb_data(wb_rdata)
    );

    always #5 clk = ~clk;

    // ---------------- peripheral model ----------------
    logic        rnd_mode = 1'b0;
    int          busy_polls = 0;          // zero status reads before done; -1 = never
    logic [31:0] noack_addr = 32'hFFFF_FFFF;
    logic [31:0] in_lo = 0, in_hi = 0, key_lo = 0, key_hi = 0, ctrl = 0;
    logic [63:0] mout = 64'h0;
    int          poll_n = 0;
    logic        pend = 1'b0;
    int          dly = 0, rdly = 0, stall_run = 0;
    logic        rbit = 1'b0;
    logic [31:0] p_rdata = 32'h0;

    function automatic logic [63:0] des_ref(input logic [63:0] k, input logic [63:0] t, input logic e);
        if (k == K && e && t == P) return C;
        if (k == K && !e && t == C) return P;
        return e ? ~(t ^ k) : (t ^ k);
    endfunction

    function automatic logic [31:0] rd_val(input logic [31:0] a);
        case (a - BASE)
            32'h08:  return mout[31:0];
            32'h0C:  return mout[63:32];
            32'h18:  return ctrl;
            32'h1C:  return {31'b0, (busy_polls >= 0) && (poll_n >= busy_polls)};
            default: return 32'h0;
        endcase
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            wb_ack <= 1'b0; wb_stall <= 1'b0; wb_rdata <= 32'h0;
            pend <= 1'b0; stall_run <= 0;
        end else begin
            wb_ack   <= 1'b0;
            wb_rdata <= 32'h0;
            rbit     <= 1'($urandom_range(1, 0));
            rdly     <= rnd_mode ? int'($urandom_range(4, 0)) : 0;
            // stall bursts capped at 3 cycles so random stalls never hit the ack timeout
            wb_stall  <= rnd_mode && (stall_run < 3) && rbit;
            stall_run <= (rnd_mode && (stall_run < 3) && rbit) ? stall_run + 1 : 0;
            if (pend) begin
                if (dly <= 1) begin
                    wb_ack <= 1'b1; wb_rdata <= p_rdata; pend <= 1'b0;
                end else begin
                    dly <= dly - 1;
                end
            end else if (wb_cyc && wb_stb && !wb_stall && wb_addr != noack_addr) begin
                if (wb_we) begin
                    case (wb_addr - BASE)
                        32'h00: in_lo  <= wb_data;
                        32'h04: in_hi  <= wb_data;
                        32'h10: key_lo <= wb_data;
                        32'h14: key_hi <= wb_data;
                        32'h18: begin
                            ctrl <= wb_data;
                            if (wb_data[0]) begin
                                mout   <= des_ref({key_hi, key_lo}, {in_hi, in_lo}, wb_data[1]);
                                poll_n <= 0;
                            end
                        end
                        default: ;
                    endcase
                end else if (wb_addr == BASE + 32'h1C) begin
                    poll_n <= poll_n + 1;
                end
                if (rdly == 0) begin
                    wb_ack   <= 1'b1;
                    wb_rdata <= wb_we ? 32'h0 : rd_val(wb_addr);
                end else begin
                    pend    <= 1'b1;
                    dly     <= rdly;
                    p_rdata <= wb_we ? 32'h0 : rd_val(wb_addr);
                end
            end
        end
    end

    // ---------------- bus monitor ----------------
    logic [64:0] trace[$];                // {we, addr, data} of each accepted strobe
    logic        outstanding = 1'b0, hold_prev = 1'b0, stb_prev = 1'b0, cyc_prev = 1'b0;
    logic [31:0] addr_prev = 32'h0;
    int          viol = 0, cyc_no = 0, stb_start = 0, cyc_drop = 0;

    always @(posedge clk) begin
        cyc_no   <= cyc_no + 1;
        stb_prev <= wb_stb;
        cyc_prev <= wb_cyc;
        if (wb_stb && !stb_prev) stb_start <= cyc_no;
        if (!wb_cyc && cyc_prev) cyc_drop <= cyc_no;
        if (reset) begin
            outstanding <= 1'b0;
            hold_prev   <= 1'b0;
        end else begin
            viol <= viol + int'(wb_stb && !wb_cyc)
                         + int'(hold_prev && !(wb_stb && wb_addr == addr_prev))
                         + int'(wb_stb && !wb_stall && outstanding)
                         + int'(wb_cyc && !wb_we && wb_data != 32'h0);
            hold_prev <= wb_stb && wb_stall;
            addr_prev <= wb_addr;
            if (!wb_cyc) outstanding <= 1'b0;
            else if (wb_stb && !wb_stall) outstanding <= !wb_ack;
            else if (wb_ack) outstanding <= 1'b0;
            if (wb_stb && !wb_stall) trace.push_back({wb_we, wb_addr, wb_data});
        end
    end

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Runs one job; lat counts cycles from acceptance (cycle 0) to rsp_valid.
    // During the hold window a competing job is offered and the response is
    // watched for stability.
    task automatic run_job(input logic [63:0] k, input logic [63:0] t, input logic e, input int hold,
                           output logic [63:0] rt, output logic re, output int lat,
                           output logic ready_after, output int hold_bad);
        int n;
        hold_bad = 0;
        @(negedge clk);
        req_key = k; req_text = t; req_encrypt = e; req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 100) begin @(negedge clk); n++; end
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 2000) begin @(posedge clk); #1; lat++; end
        if (!rsp_valid) check("rsp_wait_bound", 65'(rsp_valid), 65'd1);
        rt = rsp_text;
        re = rsp_err;
        for (int h = 0; h < hold; h++) begin
            req_key = ~k; req_text = ~t; req_valid = 1'b1;
            @(posedge clk); #1;
            if (!rsp_valid || rsp_text !== rt || rsp_err !== re || req_ready) hold_bad++;
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        ready_after = req_ready && !rsp_valid;
    endtask

    typedef struct {
        logic [63:0] key;
        logic [63:0] text;
        logic        enc;
        logic        rnd;
        int          busy;
        int          hold;
        logic [63:0] exp_text;
        logic        exp_err;
        int          exp_lat;
        int          exp_sts;
    } vec_t;

    vec_t        vecs[7];
    logic [64:0] exp_tr[9];

    initial begin
        logic [63:0] rt;
        logic        re, ra;
        int          lat, hb, sts, n;
        logic [64:0] last;

        //           key    text  enc   rnd   busy hold exp_text                  err   lat  sts
        vecs[0] = '{K,      P,    1'b1, 1'b0, 0,   0,   C,                        1'b0, 19,  1};
        vecs[1] = '{K,      C,    1'b0, 1'b0, 0,   0,   P,                        1'b0, 19,  1};
        vecs[2] = '{K,      P,    1'b1, 1'b0, 2,   0,   C,                        1'b0, 23,  3};
        vecs[3] = '{K,      P,    1'b1, 1'b1, 1,   0,   C,                        1'b0, 0,   2};
        vecs[4] = '{K,      C,    1'b0, 1'b1, 3,   0,   P,                        1'b0, 0,   4};
        vecs[5] = '{64'h0000_0000_FFFF_FFFF, 64'h1111_1111_2222_2222, 1'b1, 1'b0, 0, 10,
                    64'hEEEE_EEEE_2222_2222, 1'b0, 19, 1};
        vecs[6] = '{K,      P,    1'b1, 1'b0, -1,  0,   64'h0,                    1'b1, 141, 64};

        exp_tr[0] = {1'b1, BASE + 32'h10, 32'h9BBC_DFF1};
        exp_tr[1] = {1'b1, BASE + 32'h14, 32'h1334_5779};
        exp_tr[2] = {1'b1, BASE + 32'h00, 32'h89AB_CDEF};
        exp_tr[3] = {1'b1, BASE + 32'h04, 32'h0123_4567};
        exp_tr[4] = {1'b1, BASE + 32'h18, 32'h0000_0003};
        exp_tr[5] = {1'b0, BASE + 32'h1C, 32'h0};
        exp_tr[6] = {1'b0, BASE + 32'h08, 32'h0};
        exp_tr[7] = {1'b0, BASE + 32'h0C, 32'h0};
        exp_tr[8] = {1'b1, BASE + 32'h18, 32'h0};

        // reset state
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", 65'(req_ready), 65'd0);
        check("rst_bus_ctl", 65'({wb_cyc, wb_stb, wb_we}), 65'd0);
        check("rst_bus_addr_data", 65'({wb_addr, wb_data}), 65'd0);
        check("rst_rsp", 65'({rsp_valid, rsp_err, rsp_text}), 65'd0);
        reset = 1'b0;
        @(posedge clk); #1;
        check("ready_after_rst", 65'(req_ready), 65'd1);

        // table of jobs
        for (int i = 0; i < 7; i++) begin
            rnd_mode = vecs[i].rnd;
            busy_polls = vecs[i].busy;
            trace.delete();
            run_job(vecs[i].key, vecs[i].text, vecs[i].enc, vecs[i].hold, rt, re, lat, ra, hb);
            $display("job %0d: text=%h err=%0d lat=%0d", i, rt, re, lat);
            check($sformatf("v%0d_text", i), 65'(rt), 65'(vecs[i].exp_text));
            check($sformatf("v%0d_err", i), 65'(re), 65'(vecs[i].exp_err));
            check($sformatf("v%0d_ready_after", i), 65'(ra), 65'd1);
            check($sformatf("v%0d_hold_stable", i), 65'(hb), 65'd0);
            if (vecs[i].exp_lat != 0)
                check($sformatf("v%0d_latency", i), 65'(lat), 65'(vecs[i].exp_lat));
            sts = 0;
            foreach (trace[j]) if (trace[j][63:32] == BASE + 32'h1C) sts++;
            check($sformatf("v%0d_sts_reads", i), 65'(sts), 65'(vecs[i].exp_sts));
            check($sformatf("v%0d_go_write", i), (trace.size() > 4) ? trace[4] : 65'h0,
                  {1'b1, BASE + 32'h18, {30'b0, vecs[i].enc, 1'b1}});
            last = (trace.size() > 0) ? trace[$] : 65'h0;
            check($sformatf("v%0d_clr_write", i), last, {1'b1, BASE + 32'h18, 32'h0});
            if (i == 0) begin
                check("v0_trace_len", 65'(trace.size()), 65'd9);
                for (int j = 0; j < 9; j++)
                    check($sformatf("v0_trace%0d", j), (trace.size() > j) ? trace[j] : 65'h0, exp_tr[j]);
            end
        end

        // ack timeout on the key-hi write
        rnd_mode = 1'b0; busy_polls = 0; noack_addr = BASE + 32'h14;
        trace.delete();
        run_job(K, P, 1'b1, 0, rt, re, lat, ra, hb);
        $display("ack timeout job: text=%h err=%0d lat=%0d", rt, re, lat);
        check("acktmo_text", 65'(rt), 65'd0);
        check("acktmo_err", 65'(re), 65'd1);
        check("acktmo_latency", 65'(lat), 65'd19);
        check("acktmo_cyc_len", 65'(cyc_drop - stb_start), 65'd16);
        check("acktmo_ready_after", 65'(ra), 65'd1);
        repeat (20) @(posedge clk);
        #1;
        check("acktmo_no_more_bus", 65'(trace.size()), 65'd2);
        noack_addr = 32'hFFFF_FFFF;

        // reset while polling status
        busy_polls = -1;
        @(negedge clk);
        req_key = K; req_text = P; req_encrypt = 1'b1; req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 100) begin @(negedge clk); n++; end
        @(posedge clk); #1;
        req_valid = 1'b0;
        n = 0;
        while (!(wb_stb && wb_addr == BASE + 32'h1C) && n < 100) begin @(posedge clk); #1; n++; end
        check("rst_mid_reached_sts", 65'(wb_stb && wb_addr == BASE + 32'h1C), 65'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        $display("reset during poll: cyc=%0d stb=%0d rsp_valid=%0d", wb_cyc, wb_stb, rsp_valid);
        check("rst_mid_bus", 65'({wb_cyc, wb_stb}), 65'd0);
        check("rst_mid_rsp_valid", 65'(rsp_valid), 65'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        check("rst_mid_ready", 65'(req_ready), 65'd1);
        busy_polls = 0;
        run_job(K, C, 1'b0, 0, rt, re, lat, ra, hb);
        $display("recovery job: text=%h err=%0d lat=%0d", rt, re, lat);
        check("recover_text", 65'(rt), 65'(P));
        check("recover_err", 65'(re), 65'd0);

        check("bus_protocol", 65'(viol), 65'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
